// File: rtl/conv_window_fetch.sv
// Read master for the feature-map RAM: walks an IMG_W x IMG_H image and emits
// every unpadded 3x3 window (tap k = 3*dy+dx in bits [8k+7:8k]) over valid/ready.
module conv_window_fetch #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int BASE_ADDR = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] ram_address,
  output logic        ram_wren,
  input  logic [7:0]  ram_q,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [71:0] win_data,
  output logic [7:0]  win_row,
  output logic [7:0]  win_col,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] BASE     = 16'(BASE_ADDR);
  localparam logic [15:0] ROW_STEP = 16'(IMG_W);
  localparam logic [15:0] ROW_WRAP = 16'(IMG_W - 2);
  localparam logic [7:0]  LAST_ROW = 8'(IMG_H - 3);
  localparam logic [7:0]  LAST_COL = 8'(IMG_W - 3);

  state_t      state;
  logic [7:0]  row;
  logic [7:0]  col;
  logic [15:0] row_base;
  logic [3:0]  cnt;

  logic        last_col;
  logic        last_win;
  logic [15:0] next_row_base;
  logic [15:0] next_tap0;
  logic [15:0] tap_step;

  assign last_col      = (col == LAST_COL);
  assign last_win      = last_col && (row == LAST_ROW);
  assign next_row_base = row_base + ROW_STEP;
  assign next_tap0     = last_col ? next_row_base : (row_base + {8'd0, col} + 16'd1);
  // Taps 2 and 5 end a window row, so the following tap jumps to the next image row.
  assign tap_step      = ((cnt == 4'd3) || (cnt == 4'd6)) ? ROW_WRAP : 16'd1;

  assign ram_wren  = 1'b0;
  assign win_row   = row;
  assign win_col   = col;
  assign fsm_state = state;

  // Handshake: a window transfers on a rising edge where win_valid and win_ready
  // are both high; win_valid only rises in HOLD, and win_data/win_row/win_col
  // do not change until that edge. win_ready never reaches an output combinationally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      win_valid   <= 1'b0;
      win_data    <= '0;
      ram_address <= '0;
      row         <= '0;
      col         <= '0;
      row_base    <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= FETCH;
            busy        <= 1'b1;
            row         <= '0;
            col         <= '0;
            row_base    <= BASE;
            ram_address <= BASE;
            cnt         <= 4'd1;
          end
        end
        FETCH: begin
          // cnt counts edges since tap 0 was loaded; data lags its address by two edges.
          if (cnt <= 4'd8) ram_address <= ram_address + tap_step;
          for (int k = 0; k < 9; k++) begin
            if (cnt == 4'(k + 2)) win_data[8*k +: 8] <= ram_q;
          end
          if (cnt == 4'd10) begin
            state     <= HOLD;
            win_valid <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HOLD: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            if (last_win) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state       <= FETCH;
              cnt         <= 4'd1;
              ram_address <= next_tap0;
              if (last_col) begin
                row      <= row + 8'd1;
                col      <= '0;
                row_base <= next_row_base;
              end else begin
                col <= col + 8'd1;
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_fetch.sv
// Directed bench for conv_window_fetch: a 4x4 image at base 0 and a 5x3 image
// at base 100, each instance with its own one-cycle registered RAM.
module tb_conv_window_fetch;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;

  logic        start_a, ready_a, a_busy, a_done, a_wren, a_valid;
  logic [15:0] a_addr;
  logic [7:0]  a_q, a_row, a_col;
  logic [71:0] a_data;
  logic [1:0]  a_state;

  logic        start_b, ready_b, b_busy, b_done, b_wren, b_valid;
  logic [15:0] b_addr;
  logic [7:0]  b_q, b_row, b_col;
  logic [71:0] b_data;
  logic [1:0]  b_state;

  conv_window_fetch #(.IMG_W(4), .IMG_H(4), .BASE_ADDR(0)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .busy(a_busy), .done(a_done),
    .ram_address(a_addr), .ram_wren(a_wren), .ram_q(a_q), .win_valid(a_valid),
    .win_ready(ready_a), .win_data(a_data), .win_row(a_row), .win_col(a_col),
    .fsm_state(a_state)
  );

  conv_window_fetch #(.IMG_W(5), .IMG_H(3), .BASE_ADDR(100)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .busy(b_busy), .done(b_done),
    .ram_address(b_addr), .ram_wren(b_wren), .ram_q(b_q), .win_valid(b_valid),
    .win_ready(ready_b), .win_data(b_data), .win_row(b_row), .win_col(b_col),
    .fsm_state(b_state)
  );

  logic [7:0] mem_a [0:16383];
  logic [7:0] mem_b [0:16383];
  always @(posedge clock) begin
    a_q <= mem_a[a_addr[13:0]];
    b_q <= mem_b[b_addr[13:0]];
  end

  // scoreboard
  int tests = 0;
  int fails = 0;
  logic [87:0] exp_q[$];
  logic [87:0] got_a_q[$];
  logic [87:0] got_b_q[$];
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  logic [15:0] b_min = 16'hffff;
  logic [15:0] b_max = 16'h0000;

  localparam logic [71:0] A_FIRST = 72'h0a_09_08_06_05_04_02_01_00;
  localparam logic [71:0] A_W01   = 72'h0b_0a_09_07_06_05_03_02_01;
  localparam logic [71:0] A_LAST  = 72'h0f_0e_0d_0b_0a_09_07_06_05;
  localparam logic [71:0] B_LAST  = 72'h0e_0d_0c_09_08_07_04_03_02;

  always @(posedge clock) begin
    if (a_valid && ready_a) got_a_q.push_back({a_row, a_col, a_data});
    if (b_valid && ready_b) got_b_q.push_back({b_row, b_col, b_data});
    if (a_done) done_cnt_a++;
    if (b_done) done_cnt_b++;
    if (b_busy) begin
      if (b_addr < b_min) b_min = b_addr;
      if (b_addr > b_max) b_max = b_addr;
    end
  end

  task automatic check_eq(input string tag, input logic [87:0] got, input logic [87:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [87:0] win_exp(input int w, input int r, input int c);
    logic [71:0] d;
    d = '0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        d[8*(3*dy+dx) +: 8] = 8'((r + dy) * w + c + dx);
    return {8'(r), 8'(c), d};
  endfunction

  task automatic load_exp(input int w, input int h);
    exp_q.delete();
    for (int r = 0; r <= h - 3; r++)
      for (int c = 0; c <= w - 3; c++)
        exp_q.push_back(win_exp(w, r, c));
  endtask

  task automatic compare_q(input string tag, input bit sel);
    logic [87:0] g[$];
    if (sel) g = got_b_q; else g = got_a_q;
    check_eq({tag, "_count"}, 88'(g.size()), 88'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < g.size(); i++)
      check_eq($sformatf("%s_win%0d", tag, i), g[i], exp_q[i]);
  endtask

  // driver tasks
  task automatic pulse_start(input bit sel);
    @(negedge clock);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clock);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_valid(input bit sel, output int n);
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!(sel ? b_valid : a_valid) && n < 60);
  endtask

  task automatic wait_done(input bit sel);
    int n;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!(sel ? b_done : a_done) && n < 500);
  endtask

  task automatic check_reset_a(input string tag);
    check_eq({tag, "_busy"}, a_busy, 0);
    check_eq({tag, "_done"}, a_done, 0);
    check_eq({tag, "_valid"}, a_valid, 0);
    check_eq({tag, "_data"}, a_data, 0);
    check_eq({tag, "_addr"}, a_addr, 0);
    check_eq({tag, "_rowcol"}, {a_row, a_col}, 0);
    check_eq({tag, "_state"}, a_state, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] hold_addr;
    int bad;
    reset_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    ready_a = 1'b0; ready_b = 1'b0;
    for (int i = 0; i < 16384; i++) begin
      mem_a[i] = 8'(i);
      mem_b[i] = 8'hee;
    end
    for (int i = 0; i < 15; i++) mem_b[100 + i] = 8'(i);

    #12;
    check_reset_a("rst");
    check_eq("rst_wren", a_wren, 0);
    check_eq("rst_b_addr", b_addr, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // basic pass with latency
    ready_a = 1'b1;
    got_a_q.delete(); done_cnt_a = 0;
    pulse_start(0);
    check_eq("e0_busy", a_busy, 1);
    check_eq("e0_addr", a_addr, 0);
    wait_valid(0, n);
    check_eq("lat_first", n, 10);
    check_eq("first_rowcol", {a_row, a_col}, 0);
    check_eq("first_data", a_data, A_FIRST);
    @(posedge clock);
    #1;
    check_eq("hs_valid_fall", a_valid, 0);
    check_eq("hs_next_tap0", a_addr, 1);
    wait_valid(0, n);
    check_eq("lat_second", n, 10);
    wait_done(0);
    check_eq("basic_done", a_done, 1);
    check_eq("basic_busy_low", a_busy, 0);
    check_eq("basic_valid_low", a_valid, 0);
    @(posedge clock);
    #1;
    check_eq("done_one_cycle", a_done, 0);
    check_eq("back_idle", a_state, 0);
    check_eq("basic_last_data", got_a_q.size() == 4 ? got_a_q[3][71:0] : 72'h0, A_LAST);
    load_exp(4, 4);
    compare_q("basic", 0);
    check_eq("basic_done_cnt", done_cnt_a, 1);

    // backpressure and start while busy
    ready_a = 1'b0;
    got_a_q.delete(); done_cnt_a = 0;
    pulse_start(0);
    wait_valid(0, n);
    check_eq("bp_lat", n, 10);
    pulse_start(0);
    check_eq("hold_start_valid", a_valid, 1);
    check_eq("hold_start_rowcol", {a_row, a_col}, 0);
    @(negedge clock);
    ready_a = 1'b1;
    @(posedge clock);
    #1;
    ready_a = 1'b0;
    check_eq("bp_hs_valid", a_valid, 0);
    pulse_start(0);
    wait_valid(0, n);
    check_eq("bp_w01_valid", a_valid, 1);
    check_eq("bp_w01_rowcol", {a_row, a_col}, {8'd0, 8'd1});
    check_eq("bp_w01_data", a_data, A_W01);
    check_eq("bp_w01_addr", a_addr, 11);
    hold_addr = a_addr;
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (!a_valid || a_data !== A_W01 || a_addr !== hold_addr) bad++;
    end
    check_eq("bp_stable_cycles_bad", bad, 0);
    ready_a = 1'b1;
    wait_done(0);
    check_eq("bp_done", a_done, 1);
    @(posedge clock);
    #1;
    compare_q("bp", 0);
    check_eq("bp_done_cnt", done_cnt_a, 1);

    // asynchronous reset in the middle of window 2's fetch
    got_a_q.delete(); done_cnt_a = 0;
    pulse_start(0);
    wait_valid(0, n);
    @(posedge clock);
    repeat (3) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_a("midrst");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("midrst_no_done", done_cnt_a, 0);
    check_eq("midrst_wins", got_a_q.size(), 1);
    got_a_q.delete();
    pulse_start(0);
    wait_done(0);
    check_eq("rerun_done", a_done, 1);
    @(posedge clock);
    #1;
    compare_q("rerun", 0);
    check_eq("rerun_done_cnt", done_cnt_a, 1);

    // base offset instance
    ready_b = 1'b1;
    got_b_q.delete(); done_cnt_b = 0;
    b_min = 16'hffff; b_max = 16'h0000;
    pulse_start(1);
    check_eq("b_e0_addr", b_addr, 100);
    wait_valid(1, n);
    check_eq("b_lat", n, 10);
    wait_done(1);
    check_eq("b_done", b_done, 1);
    @(posedge clock);
    #1;
    check_eq("b_last_data", got_b_q.size() == 3 ? got_b_q[2][71:0] : 72'h0, B_LAST);
    load_exp(5, 3);
    compare_q("base", 1);
    check_eq("b_addr_min", b_min, 100);
    check_eq("b_addr_max", b_max, 114);
    check_eq("b_done_cnt", done_cnt_b, 1);
    check_eq("b_wren", b_wren, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
